// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the 8N1 UART receive path.
package uart_pkg;

    // 8N1 framing
    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned STOP_BITS            = 1;

    // 50 MHz core clock at 115200 baud
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

    // Receiver FSM states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_e;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO holding received bytes; head is shown combinationally.
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A push while full only lands if the head is leaving in the same cycle,
    // in which case it reuses the slot being freed.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    assign dout = mem_q[rptr_q[AW-1:0]];

    // Storage and pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem_q[wptr_q[AW-1:0]] <= din;
                wptr_q                <= wptr_q + 1'b1;
            end
            if (rd_en) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

endmodule : uart_rx_fifo

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the line, samples mid-bit, checks the stop
// bit and queues good bytes in a FIFO behind a valid/ready handshake.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DEPTH        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       UART_RX_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 sync1_q, sync2_q;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 push_req;
    logic                 fifo_pop;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 rx_s;

    assign rx_s = sync2_q;

    // Two-flop synchroniser for the asynchronous line, idling high
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= UART_RX_i;
            sync2_q <= sync1_q;
        end
    end

    // FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state logic: mid-bit sampling driven by a reloading down-counter
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        push_req    = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    cnt_d   = HALF_LOAD;
                    idx_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    if (!rx_s) begin
                        cnt_d   = FULL_LOAD;
                        idx_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    shreg_d[idx_q] = rx_s;
                    cnt_d          = FULL_LOAD;
                    if (idx_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    if (rx_s) begin
                        push_req = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign fifo_pop = rx_valid_o && rx_ready_i;

    // Overrun only when full and nothing leaves this cycle
    always_comb begin
        overrun_d = push_req && fifo_full && !fifo_pop;
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .din   (shreg_d),
        .pop   (fifo_pop),
        .dout  (rx_data_o),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign rx_valid_o  = !fifo_empty;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule : uart_rx

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the 8N1 UART line, the receive-side counterpart to the SoC's `UART_TX_o`. It oversamples the asynchronous line, reassembles bytes LSB-first and checks the stop bit. Good bytes are buffered in a small FIFO behind a valid/ready handshake. It consumes the SoC serial output in loopback benches and feeds received bytes to the core's peripheral bus.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200); must be ≥ 4.
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `UART_RX_i`  in  1  asynchronous serial line, idle high.
- `rx_data_o`  out  8  FIFO head byte.
- `rx_valid_o`  out  1  FIFO non-empty.
- `rx_ready_i`  in  1  consumer accepts the head byte when `rx_valid_o` is also high.
- `frame_err_o`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun_o`  out  1  one-cycle pulse: good byte dropped because the FIFO was full.
- `busy_o`  out  1  receiver is in any state other than IDLE.

## Operation

- **Input synchroniser.** `UART_RX_i` passes through 2 flops (reset to 1), giving `rx_s`. All logic uses `rx_s` only.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
- **IDLE.** When `rx_s` = 0, clear the bit counter, load the down-counter with `CLKS_PER_BIT/2 - 1` and go to START.
- **START.** When the counter reaches 0, sample `rx_s`.
  - Sample 0: load `CLKS_PER_BIT - 1`, clear the bit index, go to DATA.
  - Sample 1: false start; return to IDLE with no flags.
- **DATA.** Each time the counter reaches 0, shift `rx_s` into bit [index], LSB first, and reload the counter.
  - After index 7, go to STOP.
- **STOP.** When the counter reaches 0, sample `rx_s`.
  - Sample 1: push the byte and go to IDLE.
  - Sample 0: pulse `frame_err_o`, discard the byte, go to WAIT_HIGH.
- **WAIT_HIGH.** Stay until `rx_s` = 1, then go to IDLE. This stops a break condition from re-triggering START.
- **Counter width:** `$clog2(CLKS_PER_BIT)` bits. The counter never wraps; it is reloaded on reaching 0.
- **FIFO push.** A push into a full FIFO drops the byte and pulses `overrun_o`. Existing contents are unchanged.
- **FIFO pop.** Pop occurs on `rx_valid_o && rx_ready_i`.
- **Simultaneous push and pop:**
  - FIFO full: both happen; no overrun.
  - FIFO empty: push takes effect; the pop is impossible because valid is low.
- **Ordering:** strictly FIFO. Pointers are `$clog2(DEPTH)+1` bits with the extra wrap bit, so full = MSBs differ and low bits equal.

## Timing

- **Reset values:**
  - outputs: `rx_valid_o` = 0, `rx_data_o` = 0, `frame_err_o` = 0, `overrun_o` = 0, `busy_o` = 0.
  - internal: FSM = IDLE; pointers = 0; storage = 0; synchroniser = 1.
- **Reset mid-frame:** reset in any state returns to IDLE on the next edge, discards the partial byte and empties the FIFO.
- **Synchroniser latency:** 2 cycles from line edge to `rx_s`.
- **Bit sampling:**
  - start bit sampled `CLKS_PER_BIT/2` cycles after the falling edge is seen on `rx_s`;
  - data bit n sampled `(n+1)·CLKS_PER_BIT` cycles after the start sample;
  - stop bit sampled at `9·CLKS_PER_BIT`.
- **Byte output:** `rx_valid_o` rises the cycle after the stop-sample cycle; `rx_data_o` is valid in that same cycle.
- **Flag timing:** `frame_err_o` and `overrun_o` are registered and high for exactly the cycle after the stop sample.
- **Back-to-back frames:** IDLE is re-entered half a bit before the end of the stop bit, so a new start edge can be accepted immediately.
- **Handshake:** `rx_data_o` and `rx_valid_o` are stable while `rx_valid_o && !rx_ready_i`. After a pop, the next entry appears on the following cycle.

## Structure

- **Package `uart_pkg`:**
  - FSM state encoding, 3-bit localparams;
  - 8N1 constants: `DATA_BITS = 8`, `STOP_BITS = 1`;
  - default `CLKS_PER_BIT`.
- **Sub-module `uart_rx_fifo`:** synchronous FIFO parameterised by width (8) and `DEPTH`.
  - ports: `push`, `din`, `pop`, `dout`, `empty`, `full`;
  - the overrun decision is made in `uart_rx`.

## Test plan

All scenarios use `CLKS_PER_BIT` = 8 and `DEPTH` = 4.

1. **Single byte.** Drive 0xA5 as 8N1 with `rx_ready_i` = 0 → `rx_valid_o` rises 1 cycle after the stop sample with `rx_data_o` = 0xA5. It stays stable until ready is raised, then drops the next cycle.
2. **False start.** Pull the line low for 2 cycles → no valid, no `frame_err_o`, and `busy_o` returns to 0 at the start-sample point.
3. **Framing error then recovery.** Send 0x3C with stop bit 0, hold the line low 20 cycles, then release → one `frame_err_o` pulse, FSM in WAIT_HIGH until high. A following 0x5A is received correctly.
4. **Overrun.** Send 0x01–0x05 back-to-back with ready = 0 → `overrun_o` pulses on the 5th byte. Draining yields 0x01, 0x02, 0x03, 0x04 in order.
5. **Full FIFO with simultaneous pop.** With the FIFO full, assert ready in the same cycle a 5th byte (0x77) is pushed → no overrun. 0x77 is the last of the 4 entries then drained.
6. **Reset mid-frame.** Assert `rst` during bit 4 of 0xC3, then send 0x96 → all outputs are 0 after reset, and exactly one byte, 0x96, is received.
